// File: rtl/mem_ctrl.sv
// Byte-serial controller between the core (fetch unit, load/store buffer) and the 8-bit RAM/IO port.
// Sequences 1/2/4-byte transfers, assembles and extends load data, and pulses a per-requester done.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        ls_en,
  input  logic        ls_load,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_data,
  input  logic [2:0]  ls_size,
  input  logic        ls_signed,
  output logic        ls_done,
  output logic [31:0] ls_res,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  iss_q, iss_d;
  logic [2:0]  cap_q, cap_d;
  logic        sgn_q, sgn_d;
  logic        vld_p1_q, vld_p1_d;
  logic [1:0]  idx_p1_q, idx_p1_d;
  logic        wr_q, wr_d;
  logic        ls_done_q, ls_done_d;
  logic        if_done_q, if_done_d;
  logic [31:0] ls_res_q, ls_res_d;
  logic [31:0] if_data_q, if_data_d;

  function automatic logic [2:0] norm_size(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      3'd1:    n = 3'd1;
      3'd2:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (i)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Sub-word loads: sign- or zero-extend; the buffer is cleared at accept so high bits are never stale.
  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [2:0] n,
                                              input logic sgn);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] sx;
    logic [31:0]        r;
    b8  = signed'(w[7:0]);
    h16 = signed'(w[15:0]);
    case (n)
      3'd1: begin
        sx = b8;
        r  = sgn ? unsigned'(sx) : {24'd0, w[7:0]};
      end
      3'd2: begin
        sx = h16;
        r  = sgn ? unsigned'(sx) : {16'd0, w[15:0]};
      end
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    len_d     = len_q;
    iss_d     = iss_q;
    cap_d     = cap_q;
    sgn_d     = sgn_q;
    vld_p1_d  = vld_p1_q;
    idx_p1_d  = idx_p1_q;
    wr_d      = wr_q;
    ls_done_d = 1'b0;
    if_done_d = 1'b0;
    ls_res_d  = ls_res_q;
    if_data_d = if_data_q;

    if (!rdy) begin
      // Frozen: a read forgets its in-flight bytes and re-issues from the first uncaptured one.
      if (state_q == FETCH || state_q == LOAD) begin
        iss_d    = cap_q;
        vld_p1_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!rollback && ls_en) begin
            state_d  = ls_load ? LOAD : STORE;
            addr_d   = ls_addr;
            wdata_d  = ls_data;
            len_d    = norm_size(ls_size);
            sgn_d    = ls_signed;
            iss_d    = 3'd0;
            cap_d    = 3'd0;
            rbuf_d   = 32'd0;
            vld_p1_d = 1'b0;
            wr_d     = !ls_load && !io_buffer_full;
          end else if (!rollback && if_en) begin
            state_d  = FETCH;
            addr_d   = if_addr;
            len_d    = 3'd4;
            sgn_d    = 1'b0;
            iss_d    = 3'd0;
            cap_d    = 3'd0;
            rbuf_d   = 32'd0;
            vld_p1_d = 1'b0;
            wr_d     = 1'b0;
          end
        end

        FETCH, LOAD: begin
          if (rollback) begin
            state_d  = IDLE;
            vld_p1_d = 1'b0;
          end else begin
            // Stage p0 -> p1: the address driven this cycle returns on mem_din next cycle.
            vld_p1_d = (iss_q < len_q);
            idx_p1_d = iss_q[1:0];
            if (iss_q < len_q) iss_d = iss_q + 3'd1;
            // Stage p1: capture the returning byte; the last one completes the access.
            if (vld_p1_q) begin
              cap_d  = cap_q + 3'd1;
              rbuf_d = put_byte(rbuf_q, idx_p1_q, mem_din);
              if (cap_q + 3'd1 == len_q) begin
                state_d  = IDLE;
                vld_p1_d = 1'b0;
                if (state_q == LOAD) begin
                  ls_done_d = 1'b1;
                  ls_res_d  = extend_load(rbuf_d, len_q, sgn_q);
                end else begin
                  if_done_d = 1'b1;
                  if_data_d = rbuf_d;
                end
              end
            end
          end
        end

        STORE: begin
          // Committed stores ignore rollback; a full IO buffer rejects the current byte.
          if (io_buffer_full) begin
            wr_d = 1'b0;
          end else if (!wr_q) begin
            wr_d = 1'b1;
          end else if (iss_q + 3'd1 == len_q) begin
            wr_d      = 1'b0;
            state_d   = IDLE;
            ls_done_d = 1'b1;
          end else begin
            iss_d = iss_q + 3'd1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rbuf_q    <= 32'd0;
      len_q     <= 3'd0;
      iss_q     <= 3'd0;
      cap_q     <= 3'd0;
      sgn_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      idx_p1_q  <= 2'd0;
      wr_q      <= 1'b0;
      ls_done_q <= 1'b0;
      if_done_q <= 1'b0;
      ls_res_q  <= 32'd0;
      if_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      len_q     <= len_d;
      iss_q     <= iss_d;
      cap_q     <= cap_d;
      sgn_q     <= sgn_d;
      vld_p1_q  <= vld_p1_d;
      idx_p1_q  <= idx_p1_d;
      wr_q      <= wr_d;
      ls_done_q <= ls_done_d;
      if_done_q <= if_done_d;
      ls_res_q  <= ls_res_d;
      if_data_q <= if_data_d;
    end
  end

  assign mem_a   = addr_q + {29'd0, iss_q};
  assign mem_wr  = wr_q && rdy;
  assign ls_done = ls_done_q;
  assign ls_res  = ls_res_q;
  assign if_done = if_done_q;
  assign if_data = if_data_q;

  always_comb begin
    case (iss_q[1:0])
      2'd0:    mem_dout = wdata_q[7:0];
      2'd1:    mem_dout = wdata_q[15:8];
      2'd2:    mem_dout = wdata_q[23:16];
      default: mem_dout = wdata_q[31:24];
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model with one-cycle read latency, directed load/store/fetch steps.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        ls_en, ls_load, ls_signed, ls_done;
  logic [31:0] ls_addr, ls_data, ls_res;
  logic [2:0]  ls_size;
  logic        if_en, if_done;
  logic [31:0] if_addr, if_data;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .ls_en(ls_en), .ls_load(ls_load), .ls_addr(ls_addr), .ls_data(ls_data),
    .ls_size(ls_size), .ls_signed(ls_signed), .ls_done(ls_done), .ls_res(ls_res),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM model: address registered at the edge, byte presented during the following cycle.
  logic [7:0]  ram [0:2047];
  logic [31:0] a_d = 32'd0;
  logic        pre_we = 1'b0;
  logic [10:0] pre_a = 11'd0;
  logic [7:0]  pre_d = 8'd0;
  int          wr_cnt = 0;

  function automatic logic [10:0] ridx(input logic [31:0] a);
    return {a[16], a[9:0]};
  endfunction

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_wr) ram[ridx(mem_a)] <= mem_dout;
    if (mem_wr) wr_cnt <= wr_cnt + 1;
    a_d <= mem_a;
  end
  assign mem_din = ram[ridx(a_d)];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] aseq [16];
  logic        wseq [16];
  logic [7:0]  dseq [16];
  logic [31:0] lres;
  logic        if_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pre_a  = ridx(a);
    pre_d  = d;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // rollback / rdy-low are applied at edge E_rb_n / E_rdy_n counted from the first request edge.
  task automatic ls_op(input logic ld, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] sz, input logic sg, input int rb_n, input int rdy_n,
                       output int lat);
    ls_load = ld; ls_addr = a; ls_data = d; ls_size = sz; ls_signed = sg; ls_en = 1'b1;
    rollback = (rb_n == 0);
    rdy = (rdy_n != 0);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      rollback = (rb_n == n + 1);
      rdy = (rdy_n != n + 1);
      #1;
      if (n < 16) begin
        aseq[n] = mem_a; wseq[n] = mem_wr; dseq[n] = mem_dout;
      end
      if (if_done) if_seen = 1'b1;
      if (ls_done) begin
        lat = n; lres = ls_res;
        break;
      end
    end
    ls_en = 1'b0; rollback = 1'b0; rdy = 1'b1;
  endtask

  task automatic gap_chk(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, ls_done}, 32'd0);
    chk({tag, "_idle_wr"}, {31'd0, mem_wr}, 32'd0);
  endtask

  int lat, m, base, rb_cnt;

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    ls_en = 1'b0; ls_load = 1'b0; ls_addr = '0; ls_data = '0; ls_size = '0; ls_signed = 1'b0;
    if_en = 1'b0; if_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_ls_done", {31'd0, ls_done}, 32'd0);
    chk("rst_ls_res", ls_res, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    rst = 1'b0;

    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    poke(32'h200, 8'h80);
    poke(32'h210, 8'hFF); poke(32'h211, 8'h7F);
    poke(32'h220, 8'h01); poke(32'h221, 8'h80);
    poke(32'h40, 8'hB7); poke(32'h41, 8'h12); poke(32'h42, 8'h34); poke(32'h43, 8'hA5);

    // LW
    ls_op(1'b1, 32'h100, 32'd0, 3'd4, 1'b0, -1, -1, lat);
    chk("lw_latency", lat, 32'd5);
    chk("lw_res", lres, 32'h12345678);
    for (int i = 0; i < 4; i++) chk("lw_mem_a", aseq[i], 32'h100 + i);
    gap_chk("lw");

    // LB signed / unsigned, LH signed positive / negative
    ls_op(1'b1, 32'h200, 32'd0, 3'd1, 1'b1, -1, -1, lat);
    chk("lb_s_latency", lat, 32'd2);
    chk("lb_s_res", lres, 32'hFFFFFF80);
    ls_op(1'b1, 32'h200, 32'd0, 3'd1, 1'b0, -1, -1, lat);
    chk("lb_u_res", lres, 32'h00000080);
    gap_chk("lb");
    ls_op(1'b1, 32'h210, 32'd0, 3'd2, 1'b1, -1, -1, lat);
    chk("lh_latency", lat, 32'd3);
    chk("lh_s_pos_res", lres, 32'h00007FFF);
    ls_op(1'b1, 32'h220, 32'd0, 3'd2, 1'b1, -1, -1, lat);
    chk("lh_s_neg_res", lres, 32'hFFFF8001);

    // SW and readback
    base = wr_cnt;
    ls_op(1'b0, 32'h300, 32'hDEADBEEF, 3'd4, 1'b0, -1, -1, lat);
    chk("sw_latency", lat, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("sw_wr", {31'd0, wseq[i]}, 32'd1);
      chk("sw_mem_a", aseq[i], 32'h300 + i);
    end
    chk("sw_dout0", {24'd0, dseq[0]}, 32'hEF);
    chk("sw_dout3", {24'd0, dseq[3]}, 32'hDE);
    chk("sw_wr_done_cycle", {31'd0, wseq[4]}, 32'd0);
    chk("sw_write_count", wr_cnt - base, 32'd4);
    gap_chk("sw");
    ls_op(1'b1, 32'h300, 32'd0, 3'd4, 1'b0, -1, -1, lat);
    chk("sw_readback", lres, 32'hDEADBEEF);

    // Simultaneous SB and fetch: store wins, fetch accepted at the edge ending the done cycle
    if_seen = 1'b0;
    if_en = 1'b1; if_addr = 32'h40;
    ls_op(1'b0, 32'h30000, 32'h55, 3'd1, 1'b0, -1, -1, lat);
    chk("arb_sb_latency", lat, 32'd1);
    chk("arb_no_if_during_sb", {31'd0, if_seen}, 32'd0);
    m = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      #1;
      if (if_done) begin m = k; break; end
    end
    if_en = 1'b0;
    chk("arb_if_delay", m, 32'd6);
    chk("arb_if_data", if_data, 32'hA53412B7);
    chk("arb_sb_byte", {24'd0, ram[ridx(32'h30000)]}, 32'h55);
    @(negedge clk);
    #1;
    chk("if_done_pulse", {31'd0, if_done}, 32'd0);

    // SB stalled by io_buffer_full for 3 edges
    base = wr_cnt;
    ls_load = 1'b0; ls_addr = 32'h30000; ls_data = 32'hA7; ls_size = 3'd1; ls_signed = 1'b0;
    ls_en = 1'b1; io_buffer_full = 1'b1;
    @(negedge clk); #1;
    chk("stall_wr_e0", {31'd0, mem_wr}, 32'd0);
    @(negedge clk); #1;
    chk("stall_wr_e1", {31'd0, mem_wr}, 32'd0);
    @(negedge clk); io_buffer_full = 1'b0; #1;
    chk("stall_wr_e2", {31'd0, mem_wr}, 32'd0);
    @(negedge clk); #1;
    chk("stall_release_wr", {31'd0, mem_wr}, 32'd1);
    chk("stall_release_dout", {24'd0, mem_dout}, 32'hA7);
    @(negedge clk); #1;
    chk("stall_done", {31'd0, ls_done}, 32'd1);
    ls_en = 1'b0;
    chk("stall_write_count", wr_cnt - base, 32'd1);
    chk("stall_byte", {24'd0, ram[ridx(32'h30000)]}, 32'hA7);

    // Rollback at E2 of a fetch
    if_en = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    @(negedge clk); rollback = 1'b1; if_en = 1'b0;
    @(negedge clk); rollback = 1'b0;
    rb_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (if_done) rb_cnt++;
      @(negedge clk);
    end
    chk("rb_fetch_no_done", rb_cnt, 32'd0);
    ls_op(1'b1, 32'h200, 32'd0, 3'd1, 1'b0, -1, -1, lat);
    chk("rb_fetch_idle_after", lat, 32'd2);

    // Rollback during SW does not stop the store
    base = wr_cnt;
    ls_op(1'b0, 32'h310, 32'h11223344, 3'd4, 1'b0, 2, -1, lat);
    chk("rb_sw_latency", lat, 32'd4);
    chk("rb_sw_write_count", wr_cnt - base, 32'd4);
    chk("rb_sw_byte0", {24'd0, ram[ridx(32'h310)]}, 32'h44);
    chk("rb_sw_byte3", {24'd0, ram[ridx(32'h313)]}, 32'h11);

    // Request coinciding with rollback in IDLE is accepted one edge later
    ls_op(1'b1, 32'h200, 32'd0, 3'd1, 1'b0, 0, -1, lat);
    chk("rb_idle_latency", lat, 32'd3);
    chk("rb_idle_res", lres, 32'h00000080);

    // rdy low for one edge mid-LW and mid-SW
    ls_op(1'b1, 32'h100, 32'd0, 3'd4, 1'b0, -1, 2, lat);
    chk("rdy_lw_latency", lat, 32'd7);
    chk("rdy_lw_res", lres, 32'h12345678);
    base = wr_cnt;
    ls_op(1'b0, 32'h320, 32'hCAFEF00D, 3'd4, 1'b0, -1, 2, lat);
    chk("rdy_sw_latency", lat, 32'd5);
    chk("rdy_sw_wr_low", {31'd0, wseq[1]}, 32'd0);
    chk("rdy_sw_write_count", wr_cnt - base, 32'd4);
    ls_op(1'b1, 32'h320, 32'd0, 3'd4, 1'b0, -1, -1, lat);
    chk("rdy_sw_readback", lres, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
